// File: rtl/chunk_responder_if.sv
// chunk_responder_if: core-side chunk request/response and generated-word capture signals
interface chunk_responder_if;
   logic        chunk_request;
   logic [1:0]  request_type;
   logic [4:0]  chunk_index;
   logic        chunk_valid;
   logic [1:0]  chunk_type;
   logic [31:0] chunk;
   logic        out_chunk_valid;
   logic [1:0]  out_chunk_type;
   logic [4:0]  out_chunk_index;
   logic [31:0] out_chunk;
   logic        out_chunk_ready;
   modport master (
      output chunk_request, request_type, chunk_index,
      output out_chunk_valid, out_chunk_type, out_chunk_index, out_chunk,
      input  chunk_valid, chunk_type, chunk, out_chunk_ready
   );
   modport slave (
      input  chunk_request, request_type, chunk_index,
      input  out_chunk_valid, out_chunk_type, out_chunk_index, out_chunk,
      output chunk_valid, chunk_type, chunk, out_chunk_ready
   );
endinterface

// File: rtl/chunk_responder.sv
// chunk_responder: key/nonce banks serving the core's chunk requests and capturing its generated words
module chunk_responder #(
   parameter int KEY_WORDS   = 8,
   parameter int NONCE_WORDS = 3,
   parameter int RESP_DELAY  = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cfg_we,
   input  logic                   cfg_sel,
   input  logic [2:0]             cfg_addr,
   input  logic [31:0]            cfg_wdata,
   input  logic                   rd_sel,
   input  logic [2:0]             rd_addr,
   output logic [31:0]            rd_data,
   chunk_responder_if.slave       cif,
   output logic [KEY_WORDS-1:0]   key_loaded,
   output logic [NONCE_WORDS-1:0] nonce_loaded,
   input  logic                   vld_clr,
   output logic [2:0]             err_status,
   input  logic                   err_clr
);
   localparam int KW = KEY_WORDS > 1 ? $clog2(KEY_WORDS) : 1;
   localparam int NW = NONCE_WORDS > 1 ? $clog2(NONCE_WORDS) : 1;
   typedef enum logic [1:0] {IDLE, DELAY, RESP, GAP} state_t;
   state_t st, nxt;
   logic [31:0] key_bank [KEY_WORDS];
   logic [31:0] nonce_bank [NONCE_WORDS];
   logic [1:0] lat_type, sel_type;
   logic [4:0] lat_idx, sel_idx;
   logic [3:0] cnt;
   logic up, legal, differs, smp, lat_en, ent, req_err, sel_ld;
   logic [31:0] sel_data, wdata;
   logic cap, cap_k, cap_n, cap_err, kw_en, nw_en;
   logic [KW-1:0] kw_idx;
   logic [NW-1:0] nw_idx;
   assign legal = cif.request_type == 2'b00 ? 32'(cif.chunk_index) < KEY_WORDS
                : cif.request_type == 2'b01 && 32'(cif.chunk_index) < NONCE_WORDS;
   assign differs = {cif.request_type, cif.chunk_index} != {lat_type, lat_idx};
   assign smp = st == IDLE || (st == GAP && differs);
   // A delayed response reads the latched pair; an immediate one reads the live request
   assign sel_type = st == DELAY ? lat_type : cif.request_type;
   assign sel_idx = st == DELAY ? lat_idx : cif.chunk_index;
   assign sel_data = sel_type == 2'b01 ? nonce_bank[sel_idx[NW-1:0]] : key_bank[sel_idx[KW-1:0]];
   assign sel_ld = sel_type == 2'b01 ? nonce_loaded[sel_idx[NW-1:0]] : key_loaded[sel_idx[KW-1:0]];
   assign cif.chunk_valid = st == RESP;
   // Capture is held off until the first edge out of reset and whenever the host is writing
   assign cif.out_chunk_ready = up && !cfg_we;
   assign cap = cif.out_chunk_valid && cif.out_chunk_ready;
   assign cap_k = cap && cif.out_chunk_type == 2'b00 && 32'(cif.out_chunk_index) < KEY_WORDS;
   assign cap_n = cap && cif.out_chunk_type == 2'b01 && 32'(cif.out_chunk_index) < NONCE_WORDS;
   assign cap_err = cap && !cap_k && !cap_n;
   assign kw_en = cap_k || (cfg_we && !cfg_sel && 32'(cfg_addr) < KEY_WORDS);
   assign nw_en = cap_n || (cfg_we && cfg_sel && 32'(cfg_addr) < NONCE_WORDS);
   assign kw_idx = cfg_we ? cfg_addr[KW-1:0] : cif.out_chunk_index[KW-1:0];
   assign nw_idx = cfg_we ? cfg_addr[NW-1:0] : cif.out_chunk_index[NW-1:0];
   assign wdata = cfg_we ? cfg_wdata : cif.out_chunk;
   assign rd_data = rd_sel ? (32'(rd_addr) < NONCE_WORDS ? nonce_bank[rd_addr[NW-1:0]] : 32'h0)
                           : (32'(rd_addr) < KEY_WORDS ? key_bank[rd_addr[KW-1:0]] : 32'h0);
   // Response state register
   always_ff @(posedge clk) begin
      st <= !rst_n ? IDLE : nxt;
   end
   // Next state: IDLE and a changed pair in GAP both sample the request on this edge
   always_comb begin
      nxt = st;
      lat_en = 1'b0;
      ent = 1'b0;
      req_err = 1'b0;
      if (st == RESP) nxt = GAP;
      else if (st == DELAY && cnt == 4'd0) begin
         nxt = RESP;
         ent = 1'b1;
      end
      else if (st == GAP && !(cif.chunk_request && !differs)) nxt = IDLE;
      if (smp && cif.chunk_request) begin
         if (legal) begin
            lat_en = 1'b1;
            nxt = RESP_DELAY == 1 ? RESP : DELAY;
            ent = RESP_DELAY == 1;
         end
         else req_err = 1'b1;
      end
   end
   // Latched request, delay counter, response payload and sticky errors
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         up <= 1'b0;
         lat_type <= 2'b0;
         lat_idx <= 5'b0;
         cnt <= 4'b0;
         cif.chunk_type <= 2'b0;
         cif.chunk <= 32'h0;
         err_status <= 3'b0;
      end
      else begin
         up <= 1'b1;
         if (lat_en) begin
            lat_type <= cif.request_type;
            lat_idx <= cif.chunk_index;
         end
         cnt <= lat_en ? 4'(RESP_DELAY - 2) : st == DELAY ? cnt - 4'd1 : cnt;
         if (ent) begin
            cif.chunk_type <= sel_type;
            cif.chunk <= sel_data;
         end
         err_status <= (err_clr ? 3'b0 : err_status) | {cap_err, ent && !sel_ld, req_err};
      end
   end
   // Bank writes from host or capture; a new write wins over a same-cycle mask clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_bank <= '{default: '0};
         nonce_bank <= '{default: '0};
         key_loaded <= '0;
         nonce_loaded <= '0;
      end
      else begin
         if (kw_en) key_bank[kw_idx] <= wdata;
         if (nw_en) nonce_bank[nw_idx] <= wdata;
         key_loaded <= (vld_clr ? '0 : key_loaded) | (kw_en ? KEY_WORDS'(1) << kw_idx : '0);
         nonce_loaded <= (vld_clr ? '0 : nonce_loaded) | (nw_en ? NONCE_WORDS'(1) << nw_idx : '0);
      end
   end
endmodule

// File: tb/tb_chunk_responder.sv
// tb_chunk_responder: directed checks of chunk_responder with immediate and delayed responses
module tb_chunk_responder;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n, rst_nb, cfg_we, cfg_sel, rd_sel, vld_clr, err_clr;
   logic [2:0] cfg_addr, rd_addr;
   logic [31:0] cfg_wdata, rd_data, rd_data_b;
   logic [7:0] key_loaded, key_loaded_b;
   logic [2:0] nonce_loaded, nonce_loaded_b, err_status, err_b;
   int n_run = 0, n_fail = 0, pulses;
   chunk_responder_if ia();
   chunk_responder_if ib();
   chunk_responder #(.RESP_DELAY(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data), .cif(ia),
      .key_loaded(key_loaded), .nonce_loaded(nonce_loaded), .vld_clr(vld_clr),
      .err_status(err_status), .err_clr(err_clr)
   );
   chunk_responder #(.RESP_DELAY(4)) dut_b (
      .clk(clk), .rst_n(rst_nb), .cfg_we(1'b0), .cfg_sel(1'b0), .cfg_addr(3'd0),
      .cfg_wdata(32'd0), .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data_b), .cif(ib),
      .key_loaded(key_loaded_b), .nonce_loaded(nonce_loaded_b), .vld_clr(1'b0),
      .err_status(err_b), .err_clr(1'b0)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic req(input logic [1:0] t, input logic [4:0] i, input logic [31:0] exp, input string tag);
      ia.chunk_request = 1'b1;
      ia.request_type = t;
      ia.chunk_index = i;
      step();
      check({tag, " pulse"}, ia.chunk_valid, 1);
      check({tag, " data"}, ia.chunk, exp);
      check({tag, " type"}, ia.chunk_type, t);
      ia.chunk_request = 1'b0;
      step();
      check({tag, " fall"}, ia.chunk_valid, 0);
      step();
   endtask
   task automatic cfg_wr(input logic s, input logic [2:0] a, input logic [31:0] d);
      cfg_we = 1'b1;
      cfg_sel = s;
      cfg_addr = a;
      cfg_wdata = d;
      step();
      cfg_we = 1'b0;
   endtask
   task automatic capture(input logic [1:0] t, input logic [4:0] i, input logic [31:0] d);
      ia.out_chunk_valid = 1'b1;
      ia.out_chunk_type = t;
      ia.out_chunk_index = i;
      ia.out_chunk = d;
      step();
      ia.out_chunk_valid = 1'b0;
   endtask
   task automatic check_rd(input logic s, input logic [2:0] a, input logic [31:0] exp, input string tag);
      rd_sel = s;
      rd_addr = a;
      #1;
      check(tag, rd_data, exp);
   endtask
   initial begin
      {rst_n, rst_nb, cfg_we, cfg_sel, rd_sel, vld_clr, err_clr} = '0;
      cfg_addr = '0; rd_addr = '0; cfg_wdata = '0;
      {ia.chunk_request, ia.request_type, ia.chunk_index} = '0;
      {ia.out_chunk_valid, ia.out_chunk_type, ia.out_chunk_index, ia.out_chunk} = '0;
      {ib.chunk_request, ib.request_type, ib.chunk_index} = '0;
      {ib.out_chunk_valid, ib.out_chunk_type, ib.out_chunk_index, ib.out_chunk} = '0;
      step();
      step();
      check("rst valid", ia.chunk_valid, 0);
      check("rst chunk", ia.chunk, 0);
      check("rst type", ia.chunk_type, 0);
      check("rst key_loaded", key_loaded, 0);
      check("rst nonce_loaded", nonce_loaded, 0);
      check("rst err", err_status, 0);
      check("rst ready", ia.out_chunk_ready, 0);
      rst_n = 1'b1;
      rst_nb = 1'b1;
      step();
      check("ready after rst", ia.out_chunk_ready, 1);
      req(2'b00, 5'd4, 32'h0, "unloaded key4");
      check("err unloaded", err_status, 3'b010);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("err cleared", err_status, 3'b000);
      cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 3'd0; cfg_wdata = 32'h0;
      ia.out_chunk_valid = 1'b1; ia.out_chunk_type = 2'b00; ia.out_chunk_index = 5'd5; ia.out_chunk = 32'hdeadbeef;
      #1;
      check("ready with cfg_we", ia.out_chunk_ready, 0);
      step();
      cfg_we = 1'b0;
      ia.out_chunk_valid = 1'b0;
      check("blocked capture mask", key_loaded, 8'h00);
      check("cfg nonce mask", nonce_loaded, 3'b001);
      check_rd(1'b0, 3'd5, 32'h0, "blocked capture data");
      for (int i = 0; i < 8; i++) cfg_wr(1'b0, 3'(i), 32'h03020100 + i * 32'h04040404);
      cfg_wr(1'b1, 3'd0, 32'h0);
      cfg_wr(1'b1, 3'd1, 32'h0);
      cfg_wr(1'b1, 3'd2, 32'h09000000);
      for (int i = 0; i < 8; i++) req(2'b00, 5'(i), 32'h03020100 + i * 32'h04040404, $sformatf("key%0d", i));
      req(2'b01, 5'd0, 32'h0, "nonce0");
      req(2'b01, 5'd1, 32'h0, "nonce1");
      req(2'b01, 5'd2, 32'h09000000, "nonce2");
      check("rfc err", err_status, 3'b000);
      ia.chunk_request = 1'b1; ia.request_type = 2'b00; ia.chunk_index = 5'd2;
      step();
      check("hold pulse", ia.chunk_valid, 1);
      check("hold data", ia.chunk, 32'h0b0a0908);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         pulses += int'(ia.chunk_valid);
      end
      check("hold extra pulses", pulses, 0);
      ia.chunk_index = 5'd3;
      step();
      check("changed pulse", ia.chunk_valid, 1);
      check("changed data", ia.chunk, 32'h0f0e0d0c);
      ia.chunk_request = 1'b0;
      step();
      step();
      vld_clr = 1'b1;
      step();
      vld_clr = 1'b0;
      check("vld_clr key", key_loaded, 8'h00);
      check("vld_clr nonce", nonce_loaded, 3'b000);
      check_rd(1'b0, 3'd3, 32'h0f0e0d0c, "vld_clr keeps data");
      vld_clr = 1'b1;
      cfg_wr(1'b0, 3'd0, 32'ha0000000);
      vld_clr = 1'b0;
      check("set wins over vld_clr", key_loaded, 8'h01);
      for (int i = 0; i < 8; i++) capture(2'b00, 5'(i), 32'ha0000000 + i);
      for (int i = 0; i < 3; i++) capture(2'b01, 5'(i), 32'hb0000000 + i);
      check("capture key mask", key_loaded, 8'hff);
      check("capture nonce mask", nonce_loaded, 3'b111);
      for (int i = 0; i < 8; i++) check_rd(1'b0, 3'(i), 32'ha0000000 + i, $sformatf("rd key%0d", i));
      for (int i = 0; i < 3; i++) check_rd(1'b1, 3'(i), 32'hb0000000 + i, $sformatf("rd nonce%0d", i));
      req(2'b01, 5'd1, 32'hb0000001, "captured nonce1");
      ia.chunk_request = 1'b1; ia.request_type = 2'b00; ia.chunk_index = 5'd6;
      ia.out_chunk_valid = 1'b1; ia.out_chunk_type = 2'b00; ia.out_chunk_index = 5'd6; ia.out_chunk = 32'h12345678;
      step();
      ia.out_chunk_valid = 1'b0;
      check("collide pulse", ia.chunk_valid, 1);
      check("collide old data", ia.chunk, 32'ha0000006);
      ia.chunk_request = 1'b0;
      step();
      step();
      check_rd(1'b0, 3'd6, 32'h12345678, "collide new data");
      ia.chunk_request = 1'b1; ia.request_type = 2'b10; ia.chunk_index = 5'd0;
      step();
      check("illegal type no pulse", ia.chunk_valid, 0);
      ia.request_type = 2'b00; ia.chunk_index = 5'd9;
      step();
      check("key9 no pulse", ia.chunk_valid, 0);
      ia.chunk_request = 1'b0;
      step();
      check("illegal req err", err_status, 3'b001);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("err_clr", err_status, 3'b000);
      capture(2'b11, 5'd0, 32'h55555555);
      check("illegal capture err", err_status, 3'b100);
      cfg_wr(1'b1, 3'd5, 32'hffffffff);
      check("cfg oor mask", nonce_loaded, 3'b111);
      check("cfg oor err", err_status, 3'b100);
      check_rd(1'b1, 3'd3, 32'h0, "rd oor");
      err_clr = 1'b1;
      capture(2'b11, 5'd1, 32'h0);
      err_clr = 1'b0;
      check("set wins over err_clr", err_status, 3'b100);
      ib.out_chunk_valid = 1'b1; ib.out_chunk_type = 2'b00; ib.out_chunk_index = 5'd1; ib.out_chunk = 32'h5a5a5a5a;
      step();
      ib.out_chunk_valid = 1'b0;
      ib.chunk_request = 1'b1; ib.request_type = 2'b00; ib.chunk_index = 5'd1;
      step();
      check("d4 edge k", ib.chunk_valid, 0);
      ib.chunk_request = 1'b0;
      step();
      check("d4 edge k+1", ib.chunk_valid, 0);
      step();
      check("d4 edge k+2", ib.chunk_valid, 0);
      step();
      check("d4 edge k+3 pulse", ib.chunk_valid, 1);
      check("d4 data", ib.chunk, 32'h5a5a5a5a);
      step();
      check("d4 edge k+4", ib.chunk_valid, 0);
      check("d4 err", err_b, 3'b000);
      step();
      step();
      ib.chunk_request = 1'b1;
      step();
      rst_nb = 1'b0;
      step();
      check("d4 abort valid", ib.chunk_valid, 0);
      check("d4 abort chunk", ib.chunk, 0);
      check("d4 abort mask", key_loaded_b, 0);
      check("d4 abort ready", ib.out_chunk_ready, 0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         pulses += int'(ib.chunk_valid);
      end
      rst_nb = 1'b1;
      ib.chunk_request = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         pulses += int'(ib.chunk_valid);
      end
      check("d4 abort pulses", pulses, 0);
      check("d4 abort err", err_b, 3'b000);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/chunk_responder.md
Name: chunk_responder

Overview:
- Host-side partner of the cipher core's key/nonce chunk interface. Holds an 8-word key bank and a 3-word nonce bank.
- Answers the core's chunk_request/request_type/chunk_index requests with single-cycle chunk_valid/chunk_type/chunk responses.
- Captures the core's out_chunk stream of generated key/nonce words into the same banks.
- Sits between the host configuration bus and the core, in both the streamed and the generated key/nonce modes.

Parameters:
- KEY_WORDS, 8, key bank depth in 32-bit words
- NONCE_WORDS, 3, nonce bank depth in 32-bit words
- RESP_DELAY, 1, edges from request sample to chunk_valid rise plus one; legal range 1..15

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- cfg_we  in  1  host write strobe
- cfg_sel  in  1  0=key bank, 1=nonce bank
- cfg_addr  in  3  word index
- cfg_wdata  in  32  write data
- rd_sel  in  1  readback bank select
- rd_addr  in  3  readback word index
- rd_data  out  32  combinational readback; 0 if out of range
- chunk_request  in  1  core requests a word
- request_type  in  2  00=key, 01=nonce, others illegal
- chunk_index  in  5  requested word index
- chunk_valid  out  1  one-cycle response strobe
- chunk_type  out  2  type echoed with response
- chunk  out  32  response data
- out_chunk_valid  in  1  core presents a generated word
- out_chunk_type  in  2  00=key, 01=nonce
- out_chunk_index  in  5  generated word index
- out_chunk  in  32  generated word
- out_chunk_ready  out  1  capture ready
- key_loaded  out  KEY_WORDS  per-word valid mask
- nonce_loaded  out  NONCE_WORDS  per-word valid mask
- vld_clr  in  1  clears both masks (data kept)
- err_status  out  3  sticky: [0] illegal request, [1] unloaded word served, [2] illegal capture
- err_clr  in  1  clears err_status

Behaviour:
- Reset (rst_n=0 at an edge): FSM=IDLE; chunk_valid=0; chunk_type=0; chunk=0; banks=0; key_loaded=0; nonce_loaded=0; err_status=0; out_chunk_ready=0.
- From the first edge with rst_n=1: out_chunk_ready = !cfg_we (combinational).
- Reset asserted mid-operation aborts any pending response; no chunk_valid pulse follows.
- FSM states:
  - IDLE: on chunk_request=1 with a legal request (type 00 and index<KEY_WORDS, or type 01 and index<NONCE_WORDS), latch type/index and go to DELAY.
    - Illegal request: set err_status[0], stay in IDLE, no response.
  - DELAY: counts RESP_DELAY-1 edges. Counter width 4; RESP_DELAY=1 skips DELAY entirely.
  - RESP: chunk_valid=1 for exactly one cycle. chunk_type = latched type; chunk = bank[latched index], read at RESP entry.
    - If that word's loaded bit is 0, still send the stored value and set err_status[1].
    - Then go to GAP.
  - GAP: chunk_valid=0. Return to IDLE when chunk_request=0, or when {request_type, chunk_index} differs from the served pair; the new pair is evaluated on the same edge.
    - A held identical request never gets a second pulse.
- Timing: request sampled at edge k in IDLE → chunk_valid rises at edge k+RESP_DELAY-1 (RESP_DELAY=1: same edge) and falls one edge later.
- Request inputs are ignored outside IDLE/GAP.
- Capture: on out_chunk_valid && out_chunk_ready:
  - type 00, index<KEY_WORDS: write key[index], set key_loaded[index].
  - type 01, index<NONCE_WORDS: write nonce[index], set nonce_loaded[index].
  - Otherwise: set err_status[2], no write.
  - Capture is independent of the response FSM. Same-cycle capture and response to the same word: response carries the old value.
- Host write: cfg_we writes the selected bank word and sets its loaded bit. An out-of-range cfg_addr is ignored silently.
- vld_clr clears the masks; a same-cycle write or capture still sets its bit (set wins).
- err_clr clears err_status; a same-cycle new error still sets its bit (set wins).

Test Plan:
- RFC key load: cfg-write key 03020100,07060504,…,1f1e1d1c and nonce 00000000,00000000,09000000. Request key 0..7 then nonce 0..2, each held until chunk_valid → one pulse per word on the request-sample edge (RESP_DELAY=1), matching data, err_status=0.
- Hold request key index 2 for 6 cycles after its response → exactly one chunk_valid pulse. Change index to 3 while still held → second pulse with key[3].
- Capture stream key idx 0..7 = A0000000+i, nonce 0..2 = B0000000+i → key_loaded=FF, nonce_loaded=7, rd_data matches; request nonce 1 returns B0000001.
- Request type 10, then key index 9 → no chunk_valid, err_status=001. Assert err_clr → 000. Capture type 11 → err_status=100.
- After reset, request key 4 → chunk=00000000 with one pulse, err_status[1]=1. With cfg_we high, out_chunk_ready=0 and out_chunk is not written.
- RESP_DELAY=4: request at edge k → chunk_valid at edge k+3. rst_n low at edge k+1 → no pulse, all outputs at reset values.
